// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the memory arbiter slice: FSM states, access sizes
// and the circular index step used by the round-robin pointer.
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2
   } arbiter_state_t;

   localparam logic [1:0] BYTE = 2'd0;
   localparam logic [1:0] HALF = 2'd1;
   localparam logic [1:0] WORD = 2'd2;

   function automatic int next_index(input int current, input int count);
      return (current + 1) % count;
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side, memory-side and status signals around the arbiter.
// The master modport is the arbiter itself; slave is the surrounding system.
interface memory_arbiter_if
   import memory_arbiter_pkg::*;
#(
   parameter int SIZE                 = 32,
   parameter int REQUESTER_COUNT      = 2,
   parameter int REQUESTER_INDEX_SIZE = 1
);

   logic [REQUESTER_COUNT-1:0]        req_enable;
   logic [REQUESTER_COUNT-1:0]        req_operation;
   logic [2*REQUESTER_COUNT-1:0]      req_data_size;
   logic [SIZE*REQUESTER_COUNT-1:0]   req_address;
   logic [SIZE*REQUESTER_COUNT-1:0]   req_data_out;
   logic [REQUESTER_COUNT-1:0]        req_ready;
   logic [SIZE-1:0]                   req_data_in;

   logic                              mem_enable;
   logic                              mem_operation;
   logic [1:0]                        mem_data_size;
   logic [SIZE-1:0]                   mem_address;
   logic [SIZE-1:0]                   mem_data_out;
   logic                              mem_ready;
   logic [SIZE-1:0]                   mem_data_in;

   logic                              grant_valid;
   logic [REQUESTER_INDEX_SIZE-1:0]   grant_index;
   logic                              timeout_error;

   modport master (
      input  req_enable, req_operation, req_data_size, req_address, req_data_out,
      input  mem_ready, mem_data_in,
      output req_ready, req_data_in,
      output mem_enable, mem_operation, mem_data_size, mem_address, mem_data_out,
      output grant_valid, grant_index, timeout_error
   );

   modport slave (
      output req_enable, req_operation, req_data_size, req_address, req_data_out,
      output mem_ready, mem_data_in,
      input  req_ready, req_data_in,
      input  mem_enable, mem_operation, mem_data_size, mem_address, mem_data_out,
      input  grant_valid, grant_index, timeout_error
   );

endinterface

// File: rtl/memory_arbiter_round_robin_picker.sv
// Combinational circular search: first set request at or after the pointer.
module round_robin_picker
   import memory_arbiter_pkg::*;
#(
   parameter int REQUESTER_COUNT = 2,
   parameter int INDEX_SIZE      = 1
) (
   input  logic [REQUESTER_COUNT-1:0] request,
   input  logic [INDEX_SIZE-1:0]      pointer,
   output logic [INDEX_SIZE-1:0]      index,
   output logic                       found
);

   logic [INDEX_SIZE-1:0] candidate;

   // Walk the offsets in priority order; the first hit wins and later hits are ignored.
   always_comb begin
      index     = '0;
      found     = 1'b0;
      candidate = '0;
      for (int offset = 0; offset < REQUESTER_COUNT; offset++) begin
         candidate = INDEX_SIZE'((int'(pointer) + offset) % REQUESTER_COUNT);
         if (!found && request[candidate]) begin
            found = 1'b1;
            index = candidate;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port among several requesters, with a
// one-cycle release gap between transactions and a sticky stalled-grant watchdog.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int SIZE                 = 32,
   parameter int REQUESTER_COUNT      = 2,
   parameter int REQUESTER_INDEX_SIZE = 1,
   parameter int TIMEOUT              = 255
) (
   input logic              clock,
   input logic              reset,
   memory_arbiter_if.master bus
);

   localparam int WAIT_SIZE = $clog2(TIMEOUT + 1);

   arbiter_state_t                  state;
   logic [REQUESTER_INDEX_SIZE-1:0] rr_pointer;
   logic [REQUESTER_INDEX_SIZE-1:0] granted_index;
   logic [WAIT_SIZE-1:0]            wait_count;
   logic                            timeout_error;

   logic [REQUESTER_INDEX_SIZE-1:0] picked_index;
   logic                            pick_found;

   logic [1:0]      size_field    [REQUESTER_COUNT];
   logic [SIZE-1:0] address_field [REQUESTER_COUNT];
   logic [SIZE-1:0] data_field    [REQUESTER_COUNT];

   round_robin_picker #(
      .REQUESTER_COUNT (REQUESTER_COUNT),
      .INDEX_SIZE      (REQUESTER_INDEX_SIZE)
   ) picker (
      .request (bus.req_enable),
      .pointer (rr_pointer),
      .index   (picked_index),
      .found   (pick_found)
   );

   // Unflatten the per-requester buses so the granted index can select a whole field.
   always_comb begin
      for (int i = 0; i < REQUESTER_COUNT; i++) begin
         size_field[i]    = bus.req_data_size[i*2 +: 2];
         address_field[i] = bus.req_address[i*SIZE +: SIZE];
         data_field[i]    = bus.req_data_out[i*SIZE +: SIZE];
      end
   end

   // Arbitration FSM: a grant is only registered from IDLE, so other requesters
   // simply wait; completion or a flush of the owner advances the pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         rr_pointer    <= '0;
         granted_index <= '0;
         wait_count    <= '0;
         timeout_error <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_found) begin
                  granted_index <= picked_index;
                  wait_count    <= '0;
                  state         <= GRANTED;
               end
            end
            GRANTED: begin
               if (bus.mem_enable && bus.mem_ready) begin
                  state      <= RELEASE;
                  rr_pointer <= REQUESTER_INDEX_SIZE'(next_index(int'(granted_index), REQUESTER_COUNT));
               end else if (!bus.req_enable[granted_index]) begin
                  state      <= IDLE;
                  rr_pointer <= REQUESTER_INDEX_SIZE'(next_index(int'(granted_index), REQUESTER_COUNT));
               end
               if (!bus.mem_ready) begin
                  if (wait_count != WAIT_SIZE'(TIMEOUT))
                     wait_count <= wait_count + WAIT_SIZE'(1);
                  if (wait_count >= WAIT_SIZE'(TIMEOUT - 1))
                     timeout_error <= 1'b1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port and ready routing are live only while a grant is held.
   always_comb begin
      bus.req_data_in   = bus.mem_data_in;
      bus.req_ready     = '0;
      bus.mem_enable    = 1'b0;
      bus.mem_operation = 1'b0;
      bus.mem_data_size = '0;
      bus.mem_address   = '0;
      bus.mem_data_out  = '0;
      bus.grant_valid   = (state == GRANTED);
      bus.grant_index   = granted_index;
      bus.timeout_error = timeout_error;
      if (state == GRANTED) begin
         bus.mem_enable               = bus.req_enable[granted_index];
         bus.mem_operation            = bus.req_operation[granted_index];
         bus.mem_data_size            = size_field[granted_index];
         bus.mem_address              = address_field[granted_index];
         bus.mem_data_out             = data_field[granted_index];
         bus.req_ready[granted_index] = bus.mem_ready;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: two requesters, TIMEOUT shortened to 4.
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   memory_arbiter_if #(.SIZE(32), .REQUESTER_COUNT(2), .REQUESTER_INDEX_SIZE(1)) bus ();

   memory_arbiter #(
      .SIZE(32), .REQUESTER_COUNT(2), .REQUESTER_INDEX_SIZE(1), .TIMEOUT(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_enable    = '0;
      bus.req_operation = '0;
      bus.req_data_size = '0;
      bus.req_address   = '0;
      bus.req_data_out  = '0;
      bus.mem_ready     = 1'b0;
      bus.mem_data_in   = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      bus.mem_data_in = 32'h55;
      tick();
      tick();
      total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset grant_valid: got %b want 0", bus.grant_valid); end
      total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset mem_enable: got %b want 0", bus.mem_enable); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset req_ready: got %b want 00", bus.req_ready); end
      total++; if (bus.grant_index !== 1'b0) begin bad++; $display("[TB] FAIL reset grant_index: got %b want 0", bus.grant_index); end
      total++; if (bus.timeout_error !== 1'b0) begin bad++; $display("[TB] FAIL reset timeout_error: got %b want 0", bus.timeout_error); end
      total++; if (bus.req_data_in !== 32'h55) begin bad++; $display("[TB] FAIL reset req_data_in: got %h want 00000055", bus.req_data_in); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      bus.req_enable         = 2'b01;
      bus.req_address[31:0]  = 32'h100;
      bus.req_address[63:32] = 32'h999;
      #1;
      total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL single no_early_grant: got %b want 0", bus.grant_valid); end
      tick();
      total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("[TB] FAIL single grant_valid: got %b want 1", bus.grant_valid); end
      total++; if (bus.grant_index !== 1'b0) begin bad++; $display("[TB] FAIL single grant_index: got %b want 0", bus.grant_index); end
      total++; if (bus.mem_enable !== 1'b1) begin bad++; $display("[TB] FAIL single mem_enable: got %b want 1", bus.mem_enable); end
      total++; if (bus.mem_address !== 32'h100) begin bad++; $display("[TB] FAIL single mem_address: got %h want 00000100", bus.mem_address); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL single ready_early: got %b want 00", bus.req_ready); end
      tick();
      tick();
      bus.mem_ready = 1'b1;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single req_ready: got %b want 01", bus.req_ready); end
      tick();
      bus.mem_ready  = 1'b0;
      bus.req_enable = 2'b00;
      #1;
      total++; if (bus.grant_valid !== 1'b0 || bus.mem_enable !== 1'b0 || bus.req_ready !== 2'b00) begin
         bad++; $display("[TB] FAIL single release: got valid=%b en=%b ready=%b want 0 0 00", bus.grant_valid, bus.mem_enable, bus.req_ready);
      end
      tick();
      total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL single idle: got %b want 0", bus.grant_valid); end
      bus.req_enable = 2'b11;
      tick();
      total++; if (bus.grant_index !== 1'b1) begin bad++; $display("[TB] FAIL single rr_pointer_next: got %b want 1", bus.grant_index); end
      total++; if (bus.timeout_error !== 1'b0) begin bad++; $display("[TB] FAIL single no_timeout: got %b want 0", bus.timeout_error); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] expected_order;
      logic [1:0] expected_ready;
      expected_order = 4'b1010;
      do_reset();
      bus.req_enable = 2'b11;
      for (int n = 0; n < 4; n++) begin
         tick();
         total++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== expected_order[n]) begin
            bad++; $display("[TB] FAIL b2b grant%0d: got valid=%b idx=%b want 1 %b", n, bus.grant_valid, bus.grant_index, expected_order[n]);
         end
         bus.mem_ready = 1'b1;
         #1;
         expected_ready = expected_order[n] ? 2'b10 : 2'b01;
         total++; if (bus.req_ready !== expected_ready) begin bad++; $display("[TB] FAIL b2b ready%0d: got %b want %b", n, bus.req_ready, expected_ready); end
         tick();
         bus.mem_ready = 1'b0;
         #1;
         total++; if (bus.grant_valid !== 1'b0 || bus.mem_enable !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b release%0d: got valid=%b en=%b want 0 0", n, bus.grant_valid, bus.mem_enable);
         end
         tick();
         total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b idle%0d: got %b want 0", n, bus.grant_valid); end
      end
   endtask

   task automatic test_store_load();
      do_reset();
      bus.req_enable          = 2'b10;
      bus.req_operation       = 2'b10;
      bus.req_data_size       = {WORD, BYTE};
      bus.req_address         = {32'h200, 32'h300};
      bus.req_data_out        = {32'hDEADBEEF, 32'h11111111};
      #1;
      total++; if (bus.mem_address !== 32'h0 || bus.mem_data_out !== 32'h0) begin
         bad++; $display("[TB] FAIL store idle_zero: got addr=%h data=%h want 0 0", bus.mem_address, bus.mem_data_out);
      end
      tick();
      total++; if (bus.grant_index !== 1'b1) begin bad++; $display("[TB] FAIL store grant_index: got %b want 1", bus.grant_index); end
      total++; if (bus.mem_data_out !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL store mem_data_out: got %h want deadbeef", bus.mem_data_out); end
      total++; if (bus.mem_operation !== 1'b1) begin bad++; $display("[TB] FAIL store mem_operation: got %b want 1", bus.mem_operation); end
      total++; if (bus.mem_data_size !== 2'd2) begin bad++; $display("[TB] FAIL store mem_data_size: got %0d want 2", bus.mem_data_size); end
      total++; if (bus.mem_address !== 32'h200) begin bad++; $display("[TB] FAIL store mem_address: got %h want 00000200", bus.mem_address); end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready  = 1'b0;
      bus.req_enable = 2'b01;
      tick();
      tick();
      total++; if (bus.grant_index !== 1'b0 || bus.mem_operation !== 1'b0) begin
         bad++; $display("[TB] FAIL load grant: got idx=%b op=%b want 0 0", bus.grant_index, bus.mem_operation);
      end
      bus.mem_data_in = 32'h80;
      bus.mem_ready   = 1'b1;
      #1;
      total++; if (bus.req_data_in !== 32'h80) begin bad++; $display("[TB] FAIL load req_data_in: got %h want 00000080", bus.req_data_in); end
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL load req_ready: got %b want 01", bus.req_ready); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.req_enable = 2'b11;
      tick();
      tick();
      bus.req_enable = 2'b10;
      #1;
      total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("[TB] FAIL flush mem_enable_drop: got %b want 0", bus.mem_enable); end
      tick();
      total++; if (bus.grant_valid !== 1'b0 || bus.mem_enable !== 1'b0) begin
         bad++; $display("[TB] FAIL flush idle: got valid=%b en=%b want 0 0", bus.grant_valid, bus.mem_enable);
      end
      tick();
      total++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 1'b1) begin
         bad++; $display("[TB] FAIL flush next_grant: got valid=%b idx=%b want 1 1", bus.grant_valid, bus.grant_index);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.req_enable = 2'b01;
      tick();
      tick();
      tick();
      tick();
      total++; if (bus.timeout_error !== 1'b0) begin bad++; $display("[TB] FAIL timeout early: got %b want 0", bus.timeout_error); end
      tick();
      total++; if (bus.timeout_error !== 1'b1) begin bad++; $display("[TB] FAIL timeout set: got %b want 1", bus.timeout_error); end
      total++; if (bus.grant_valid !== 1'b1 || bus.mem_enable !== 1'b1) begin
         bad++; $display("[TB] FAIL timeout held: got valid=%b en=%b want 1 1", bus.grant_valid, bus.mem_enable);
      end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready  = 1'b0;
      bus.req_enable = 2'b00;
      tick();
      tick();
      total++; if (bus.timeout_error !== 1'b1) begin bad++; $display("[TB] FAIL timeout sticky: got %b want 1", bus.timeout_error); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_enable = 2'b01;
      tick();
      tick();
      tick();
      tick();
      tick();
      total++; if (bus.mem_enable !== 1'b1 || bus.timeout_error !== 1'b1) begin
         bad++; $display("[TB] FAIL midreset setup: got en=%b err=%b want 1 1", bus.mem_enable, bus.timeout_error);
      end
      reset = 1'b1;
      tick();
      total++; if (bus.mem_enable !== 1'b0 || bus.grant_valid !== 1'b0 || bus.timeout_error !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset clear: got en=%b valid=%b err=%b want 0 0 0", bus.mem_enable, bus.grant_valid, bus.timeout_error);
      end
      reset = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_store_load();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
